picorv32_mem_responder: RTL and testbench
=========================================

// Module: picorv32_mem_responder
// PURPOSE
//   Synthesizable responder (memory side) for the picorv32 native memory interface.
//   Serves fetches, loads and stores from an internal halfword-organized RAM, with a
//   runtime-programmable wait-state count.
//   Supports halfword-aligned 32-bit fetches (addr[1]=1) as needed for COMPRESSED_ISA.
//   Sits opposite the core in formal and simulation benches, replacing free mem_rdata/mem_ready inputs.
// PARAMETERS
//   ADDR_BITS  11   decoded byte-address bits; RAM = 2^(ADDR_BITS-1) halfwords (1024)
//   WAIT_BITS  5    width of cfg_wait
//   INIT_FILE  ""   $readmemh image (16-bit words); empty = RAM uninitialized
// PORTS
//   clk          in   1          clock, all logic on posedge
//   reset        in   1          synchronous, active-high
//   mem_valid    in   1          request from core; held until mem_ready
//   mem_instr    in   1          request is an instruction fetch
//   mem_addr     in   32         byte address
//   mem_wdata    in   32         store data
//   mem_wstrb    in   4          byte enables; 0 = read
//   mem_ready    out  1          one-cycle completion pulse
//   mem_rdata    out  32         read data, valid when mem_ready=1
//   cfg_wait     in   WAIT_BITS  wait states inserted before mem_ready
//   err_oob      out  1          sticky: access with mem_addr[31:ADDR_BITS] != 0
//   err_align    out  1          sticky: addr[0]=1, or store with addr[1]=1
//   err_protocol out  1          sticky: mem_valid dropped or mem_addr changed before mem_ready
// BEHAVIOUR
//   Reset: state=IDLE, mem_ready=0, mem_rdata=0, all err_* = 0. RAM contents are not cleared.
//   FSM IDLE -> WAIT -> RESP -> IDLE.
//   IDLE:
//     - On mem_valid=1: latch addr/wdata/wstrb/instr and load cnt=cfg_wait.
//     - Next state is WAIT, or RESP if cfg_wait==0.
//   WAIT: decrement cnt each cycle; at cnt==1 go to RESP.
//   Latency: mem_ready is high exactly cfg_wait+1 cycles after the first cycle with mem_valid=1.
//   RESP:
//     - mem_ready=1 for exactly one cycle; mem_rdata is valid in that same cycle.
//     - The store commits in this cycle.
//     - Next state is IDLE. mem_valid in the following IDLE cycle is a new request (no back-to-back ready).
//   Read, h = addr[ADDR_BITS-1:1]:
//     - mem_rdata = {ram[h+1], ram[h]}; h+1 wraps modulo 2^(ADDR_BITS-1).
//     - mem_rdata holds its value until the next RESP. Stores leave mem_rdata unchanged.
//   Store:
//     - Requires addr[1:0]==0.
//     - Byte i written iff wstrb[i]; low half goes to ram[h], high half to ram[h+1].
//   addr[0]=1, or store with addr[1]=1: set err_align; no RAM write; rdata=0; still completes.
//   OOB: set err_oob; rdata=0; store ignored; still completes with normal latency (never hangs).
//   mem_valid=0 in WAIT or RESP: abort to IDLE, no mem_ready, no write, set err_protocol.
//   mem_addr differs from latched addr in WAIT: set err_protocol; complete using latched values.
//   cfg_wait is sampled only in IDLE; changes mid-request have no effect.
//   reset mid-request: next cycle is IDLE, mem_ready=0, pending store dropped.
//   Simultaneous reset and RESP: reset wins; no write.
// STRUCTURE
//   Shared package/include picorv32_mem_pkg:
//     - state encodings IDLE/WAIT/RESP
//     - helper functions hw_index(addr) and is_oob(addr, ADDR_BITS)
//   Sub-module picorv32_hw_bank_ram, instantiated twice (even/odd halfword banks):
//     - 1 synchronous read port, 1 write port with 2 byte enables
//     - the even bank is read at index ceil(h/2), the odd bank at floor(h/2)
//     - this yields ram[h] and ram[h+1] in one cycle; issue the bank read in the cycle entering RESP
//   Top: FSM, wait counter, error flags, bank/half swap mux for odd h.
// TESTING
//   1. cfg_wait=0, ram[0]=0x0513, ram[1]=0x0000, read 0x000
//      -> mem_ready at cycle +1, rdata=0x00000513.
//   2. ram[1]=0x4501, ram[2]=0x1234, fetch 0x002
//      -> rdata=0x12344501, err_align=0.
//   3. ram[1023]=0xBEEF, ram[0]=0x0513, read 0x7FE
//      -> rdata=0x0513BEEF (wrap).
//   4. Store 0xAABBCCDD, wstrb=4'b0101 to 0x010 over 0, then read 0x010
//      -> rdata=0x00BB00DD.
//   5. cfg_wait=3 -> mem_ready exactly at cycle +4.
//      Repeat, dropping mem_valid at cycle +2 -> no ready, err_protocol=1.
//   6. Read 0x1000 -> rdata=0, err_oob=1, ready at cfg_wait+1.
//      Then reset during WAIT -> mem_ready=0, all err_* = 0 next cycle.

Source files
------------

// File: rtl/picorv32_mem_pkg.sv
// picorv32_mem_pkg: shared state encoding and address helpers for the picorv32 memory responder
package picorv32_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    function automatic logic [31:0] hw_index(input logic [31:0] addr, input int abits);
        return (addr & ((32'd1 << abits) - 32'd1)) >> 1;
    endfunction

    function automatic logic is_oob(input logic [31:0] addr, input int abits);
        return (addr >> abits) != 32'd0;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr, input logic [3:0] wstrb);
        return addr[0] || (wstrb != 4'd0 && addr[1]);
    endfunction

endpackage

// File: rtl/picorv32_hw_bank_ram.sv
// picorv32_hw_bank_ram: halfword RAM bank, one synchronous read port and one byte-enabled write port
module picorv32_hw_bank_ram #(
    parameter int IDX_BITS = 9
) (
    input  logic                clk,
    input  logic                re,
    input  logic [IDX_BITS-1:0] raddr,
    output logic [15:0]         rdata,
    input  logic [1:0]          we,
    input  logic [IDX_BITS-1:0] waddr,
    input  logic [15:0]         wdata
);

    logic [15:0] mem [2**IDX_BITS];

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
        if (we[0]) mem[waddr][7:0] <= wdata[7:0];
        if (we[1]) mem[waddr][15:8] <= wdata[15:8];
    end

endmodule

// File: rtl/picorv32_mem_responder.sv
// picorv32_mem_responder: memory-side responder for the picorv32 native interface
// Two interleaved halfword banks let a halfword-aligned 32-bit read complete in one access.
module picorv32_mem_responder
    import picorv32_mem_pkg::*;
#(
    parameter int ADDR_BITS = 11,
    parameter int WAIT_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_valid,
    input  logic                 mem_instr,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wstrb,
    output logic                 mem_ready,
    output logic [31:0]          mem_rdata,
    input  logic [WAIT_BITS-1:0] cfg_wait,
    output logic                 err_oob,
    output logic                 err_align,
    output logic                 err_protocol
);

    localparam int BB = ADDR_BITS - 2;

    state_t               state;
    logic [WAIT_BITS-1:0] cnt;
    logic [31:0]          lat_addr, lat_wdata;
    logic [3:0]           lat_wstrb;
    logic                 lat_instr;
    logic                 rd_zero, rd_swap;
    logic [31:0]          src_addr;
    logic [3:0]           src_wstrb;
    logic                 src_bad, lat_bad, enter_resp, bank_re, bank_we;
    logic [15:0]          even_q, odd_q;

    // The bank read must be issued as RESP is entered; from IDLE the request is not latched yet.
    assign src_addr   = (state == IDLE) ? mem_addr : lat_addr;
    assign src_wstrb  = (state == IDLE) ? mem_wstrb : lat_wstrb;
    assign src_bad    = is_oob(src_addr, ADDR_BITS) || is_misaligned(src_addr, src_wstrb);
    assign lat_bad    = is_oob(lat_addr, ADDR_BITS) || is_misaligned(lat_addr, lat_wstrb);
    assign enter_resp = mem_valid && !reset &&
                        ((state == IDLE && cfg_wait == '0) || (state == WAIT && cnt == WAIT_BITS'(1)));
    assign bank_re    = enter_resp && src_wstrb == 4'd0;
    assign bank_we    = state == RESP && mem_valid && !reset && lat_wstrb != 4'd0 && !lat_bad;
    assign mem_ready  = state == RESP && mem_valid && !reset;
    assign mem_rdata  = rd_zero ? '0 : rd_swap ? {even_q, odd_q} : {odd_q, even_q};

    // Even bank holds ram[2k], odd bank ram[2k+1]; the +1 carry wraps through the truncation.
    picorv32_hw_bank_ram #(.IDX_BITS(BB)) u_even (
        .clk   (clk),
        .re    (bank_re),
        .raddr (BB'((hw_index(src_addr, ADDR_BITS) + 32'd1) >> 1)),
        .rdata (even_q),
        .we    ({2{bank_we}} & lat_wstrb[1:0]),
        .waddr (BB'(hw_index(lat_addr, ADDR_BITS) >> 1)),
        .wdata (lat_wdata[15:0])
    );

    picorv32_hw_bank_ram #(.IDX_BITS(BB)) u_odd (
        .clk   (clk),
        .re    (bank_re),
        .raddr (BB'(hw_index(src_addr, ADDR_BITS) >> 1)),
        .rdata (odd_q),
        .we    ({2{bank_we}} & lat_wstrb[3:2]),
        .waddr (BB'(hw_index(lat_addr, ADDR_BITS) >> 1)),
        .wdata (lat_wdata[31:16])
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rd_zero      <= 1'b1;
            rd_swap      <= 1'b0;
            err_oob      <= 1'b0;
            err_align    <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            case (state)
                IDLE: if (mem_valid) begin
                    lat_addr  <= mem_addr;
                    lat_wdata <= mem_wdata;
                    lat_wstrb <= mem_wstrb;
                    lat_instr <= mem_instr;
                    cnt       <= cfg_wait;
                    state     <= (cfg_wait == '0) ? RESP : WAIT;
                    err_oob   <= err_oob | is_oob(mem_addr, ADDR_BITS);
                    err_align <= err_align | is_misaligned(mem_addr, mem_wstrb);
                end
                WAIT: if (!mem_valid) begin
                    state        <= IDLE;
                    err_protocol <= 1'b1;
                end else begin
                    if ({mem_instr, mem_addr} != {lat_instr, lat_addr}) err_protocol <= 1'b1;
                    cnt <= cnt - 1'b1;
                    if (cnt == WAIT_BITS'(1)) state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                    if (!mem_valid) err_protocol <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            // Valid stores keep the previous read data; reads and faulting accesses replace it.
            if (enter_resp && (src_wstrb == 4'd0 || src_bad)) begin
                rd_zero <= src_bad;
                rd_swap <= src_addr[1];
            end
        end
    end

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// tb_picorv32_mem_responder: directed requests against a halfword-array model of the responder
module tb_picorv32_mem_responder;

    logic        clk = 1'b0, reset = 1'b1;
    logic        mem_valid = 1'b0, mem_instr = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [4:0]  cfg_wait = '0;
    logic        mem_ready, err_oob, err_align, err_protocol;
    logic [31:0] mem_rdata;

    picorv32_mem_responder dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .cfg_wait(cfg_wait),
        .err_oob(err_oob), .err_align(err_align), .err_protocol(err_protocol)
    );

    always #5 clk = ~clk;

    int          cyc = 0, exp_cyc = -1, checks = 0, failures = 0;
    logic [15:0] ram_m [1024];
    logic [31:0] exp_rdata = '0, held = '0, rd;
    bit          m_oob, m_align, m_prot, busy, checking;
    int          lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (checking && !reset) begin
            if (cyc == exp_cyc) begin
                chk("ready_pulse", 32'(mem_ready), 32'd1);
                chk("rdata", mem_rdata, exp_rdata);
                held = exp_rdata;
            end else begin
                chk("ready_low", 32'(mem_ready), 32'd0);
                chk("rdata_hold", mem_rdata, held);
            end
            if (!busy) begin
                chk("err_oob", 32'(err_oob), 32'(m_oob));
                chk("err_align", 32'(err_align), 32'(m_align));
                chk("err_protocol", 32'(err_protocol), 32'(m_prot));
            end
        end
    end

    // mode 0: normal, 1: drop valid at +2, 2: change addr and cfg_wait at +2, 3: reset at +1
    task automatic req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input bit ins, input int mode, output logic [31:0] r, output int l);
        logic [9:0] h, h1;
        bit         store, bad;
        int         c0;
        @(posedge clk); #1;
        store = ws != 4'd0;
        bad   = a[0] || (store && a[1]) || a[31:11] != 21'd0;
        h     = a[10:1];
        h1    = h + 10'd1;
        if (a[31:11] != 21'd0) m_oob = 1'b1;
        if (a[0] || (store && a[1])) m_align = 1'b1;
        exp_rdata = bad ? 32'd0 : store ? held : {ram_m[h1], ram_m[h]};
        if (store && !bad) begin
            if (ws[0]) ram_m[h][7:0]   = wd[7:0];
            if (ws[1]) ram_m[h][15:8]  = wd[15:8];
            if (ws[2]) ram_m[h1][7:0]  = wd[23:16];
            if (ws[3]) ram_m[h1][15:8] = wd[31:24];
        end
        mem_addr = a; mem_wdata = wd; mem_wstrb = ws; mem_instr = ins; mem_valid = 1'b1;
        busy = 1'b1; c0 = cyc; exp_cyc = cyc + int'(cfg_wait) + 1;
        r = '0; l = -1;
        if (mode == 3) begin
            @(posedge clk); #1;
            reset = 1'b1; exp_cyc = -1; m_oob = 0; m_align = 0; m_prot = 0; held = '0;
            @(posedge clk); #1;
            reset = 1'b0; mem_valid = 1'b0; busy = 1'b0;
            return;
        end
        if (mode != 0) begin
            repeat (2) begin @(posedge clk); #1; end
            m_prot = 1'b1;
            if (mode == 1) begin
                mem_valid = 1'b0; exp_cyc = -1;
                repeat (2) begin @(posedge clk); #1; end
                busy = 1'b0;
                return;
            end
            mem_addr = a ^ 32'h40; cfg_wait = 5'd0;
        end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (mem_ready) begin l = cyc - c0; r = mem_rdata; break; end
        end
        if (l < 0) begin
            checks++; failures++;
            $display("FAIL ready_timeout: got no mem_ready expected one at cycle %0d", exp_cyc);
        end
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_wstrb = '0; mem_instr = 1'b0; busy = 1'b0; exp_cyc = -1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; checking = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(mem_ready), 32'd0);
        chk("reset_rdata", mem_rdata, 32'd0);
        chk("reset_errs", {29'd0, err_oob, err_align, err_protocol}, 32'd0);

        req(32'h000, 32'h0000_0513, 4'hF, 0, 0, rd, lat);
        req(32'h000, 32'd0, 4'h0, 0, 0, rd, lat);
        chk("t1_rdata", rd, 32'h0000_0513);
        chk("t1_latency", 32'(lat), 32'd1);

        req(32'h000, 32'h4501_0513, 4'hF, 0, 0, rd, lat);
        req(32'h004, 32'h0000_1234, 4'hF, 0, 0, rd, lat);
        req(32'h002, 32'd0, 4'h0, 1, 0, rd, lat);
        chk("t2_fetch_odd", rd, 32'h1234_4501);
        chk("t2_err_align", 32'(err_align), 32'd0);

        req(32'h7FC, 32'hBEEF_0000, 4'hF, 0, 0, rd, lat);
        req(32'h7FE, 32'd0, 4'h0, 0, 0, rd, lat);
        chk("t3_wrap", rd, 32'h0513_BEEF);

        req(32'h010, 32'd0, 4'hF, 0, 0, rd, lat);
        req(32'h010, 32'hAABB_CCDD, 4'b0101, 0, 0, rd, lat);
        req(32'h010, 32'd0, 4'h0, 0, 0, rd, lat);
        chk("t4_byte_strobe", rd, 32'h00BB_00DD);

        cfg_wait = 5'd3;
        req(32'h000, 32'd0, 4'h0, 0, 0, rd, lat);
        chk("t5_latency", 32'(lat), 32'd4);
        chk("t5_rdata", rd, 32'h4501_0513);
        req(32'h000, 32'd0, 4'h0, 0, 1, rd, lat);
        chk("t5_drop_protocol", 32'(err_protocol), 32'd1);
        cfg_wait = 5'd3;
        req(32'h7FE, 32'd0, 4'h0, 0, 2, rd, lat);
        chk("t5_addr_change_latency", 32'(lat), 32'd4);
        chk("t5_addr_change_rdata", rd, 32'h0513_BEEF);

        cfg_wait = 5'd2;
        req(32'h1000, 32'd0, 4'h0, 0, 0, rd, lat);
        chk("t6_oob_rdata", rd, 32'd0);
        chk("t6_oob_latency", 32'(lat), 32'd3);
        chk("t6_err_oob", 32'(err_oob), 32'd1);
        cfg_wait = 5'd3;
        req(32'h000, 32'd0, 4'h0, 0, 3, rd, lat);
        @(negedge clk);
        chk("t6_reset_errs", {29'd0, err_oob, err_align, err_protocol}, 32'd0);
        chk("t6_reset_ready", 32'(mem_ready), 32'd0);

        cfg_wait = 5'd1;
        req(32'h7FE, 32'd0, 4'h0, 0, 0, rd, lat);
        chk("t7_ram_kept", rd, 32'h0513_BEEF);
        req(32'h001, 32'd0, 4'h0, 0, 0, rd, lat);
        chk("t7_misaligned_rdata", rd, 32'd0);
        chk("t7_err_align", 32'(err_align), 32'd1);
        req(32'h002, 32'hFFFF_FFFF, 4'hF, 0, 0, rd, lat);
        chk("t7_bad_store_rdata", rd, 32'd0);
        req(32'h000, 32'd0, 4'h0, 0, 0, rd, lat);
        chk("t7_bad_store_no_write", rd, 32'h4501_0513);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
